// File: rtl/pipe_skid32.sv
// Two-entry valid/ready pipeline buffer (head + skid slot).
// in_ready comes only from registered state, so no ready path runs through this stage.
module pipe_skid32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ONE     = 2'd1,
    FULL    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             take;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Output decode; the unreachable encoding presents as empty.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    level     = 2'd0;
    case (state_q)
      ONE: begin
        out_valid = 1'b1;
        level     = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        level     = 2'd2;
      end
      default: ;
    endcase
  end

  assign out_data = head_q;
  assign accept   = in_valid & in_ready;
  assign take     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers keep stale contents; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({accept, take})
            2'b11: head_d = in_data;
            2'b10: begin
              skid_d  = in_data;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (take) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid32.sv
// Directed plus randomized bench for pipe_skid32 against a queue-based FIFO model.
module tb_pipe_skid32;

  logic        clk = 1'b0;
  logic        clrn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  level;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  logic [31:0] got[$];

  pipe_skid32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, q.size() < 2});
    chk({tag, ".level"},     {30'd0, level},     q.size());
    if (q.size() > 0)
      chk({tag, ".out_data"}, out_data, q[0]);
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then check.
  task automatic step(input string tag, input logic iv, input logic [31:0] d,
                      input logic ordy, input logic fl);
    bit acc, tk;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (q.size() < 2);
    tk  = ordy && (q.size() > 0);
    @(posedge clk);
    if (tk) got.push_back(q[0]);
    if (fl) q.delete();
    else begin
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    #1;
    $display("[%0t] %s iv=%0b d=%h ordy=%0b fl=%0b -> ov=%0b od=%h ir=%0b lvl=%0d",
             $time, tag, iv, d, ordy, fl, out_valid, out_data, in_ready, level);
    check_model(tag);
  endtask

  initial begin
    clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst.level",     {30'd0, level},     32'd0);
    chk("rst.out_data",  out_data,           32'd0);
    #10 clrn = 1'b1;

    // Streaming with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      step("stream", 1'b1, i, 1'b1, 1'b0);
      chk("stream.level", {30'd0, level}, 32'd1);
      chk("stream.data", out_data, i);
    end
    step("stream_drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure and stall stability.
    got.delete();
    step("bp1", 1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    step("bp2", 1'b1, 32'hAAAA0002, 1'b0, 1'b0);
    chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp.level", {30'd0, level}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      step("stall", 1'b1, 32'hAAAA0003, 1'b0, 1'b0);
      chk("stall.data", out_data, 32'hAAAA0001);
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    end
    step("bp_rel", 1'b1, 32'hAAAA0003, 1'b1, 1'b0);
    step("bp_rel", 1'b1, 32'hAAAA0003, 1'b1, 1'b0);
    step("bp_rel", 1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp.count", got.size(), 32'd3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk("bp.order", got[i], 32'hAAAA0001 + i);

    // Flush from FULL drops the offered word.
    step("fl_fill", 1'b1, 32'h11110001, 1'b0, 1'b0);
    step("fl_fill", 1'b1, 32'h11110002, 1'b0, 1'b0);
    step("flush", 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("flush.level", {30'd0, level}, 32'd0);
    chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
    step("post_flush", 1'b0, 32'd0, 1'b1, 1'b0);
    chk("post_flush.out_valid", {31'd0, out_valid}, 32'd0);

    // Single-entry turnover.
    step("turn_fill", 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    step("turn_take", 1'b0, 32'd0, 1'b1, 1'b0);
    chk("turn.level0", {30'd0, level}, 32'd0);
    step("turn_acc", 1'b1, 32'h12345678, 1'b0, 1'b0);
    chk("turn.out_valid", {31'd0, out_valid}, 32'd1);
    chk("turn.out_data", out_data, 32'h12345678);

    // Asynchronous reset mid-cycle while FULL.
    step("rst_fill", 1'b1, 32'h55550002, 1'b0, 1'b0);
    chk("rst_fill.level", {30'd0, level}, 32'd2);
    in_valid = 1'b0;
    #2 clrn = 1'b0;
    #1;
    q.delete();
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.in_ready",  {31'd0, in_ready},  32'd1);
    chk("arst.level",     {30'd0, level},     32'd0);
    chk("arst.out_data",  out_data,           32'd0);
    #3 clrn = 1'b1;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
